// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem
// Brief    : RV32I load/store unit with local data memory and a handshaked
//            character-output MMIO port.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_ADDR = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mmio_valid,
    output logic [7:0]  mmio_data,
    input  logic        mmio_ready
);
    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_MMIO = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_mmio_valid;
    logic [7:0]  r_mmio_data;
    logic [31:0] r_mem [DEPTH];

    logic [IW-1:0] w_idx;
    logic [31:0]   w_lane;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wdata_sh;
    logic [3:0]    w_be;
    logic          w_accept;
    logic          w_is_mmio;
    logic          w_in_range;
    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_fault;
    logic          w_mem_we;

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign mmio_valid = r_mmio_valid;
    assign mmio_data  = r_mmio_data;

    assign w_idx      = req_addr[AW-1:2];
    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_is_mmio  = (req_addr == MMIO_ADDR);
    assign w_in_range = ((req_addr >> AW) == 32'd0);
    assign w_lane     = r_mem[w_idx] >> {req_addr[1:0], 3'b000};
    assign w_wdata_sh = req_wdata << {req_addr[1:0], 3'b000};

    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !req_we;
            default:                w_f3_ok = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: w_be = 4'b0001 << req_addr[1:0];
            2'b01: begin
                w_misalign = req_addr[0];
                w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_misalign = (req_addr[1:0] != 2'b00);
                w_be       = 4'b1111;
            end
            default: w_be = 4'b0000;
        endcase
    end

    // MMIO_ADDR is exempt from the range fault even though it lies outside memory.
    assign w_fault  = !w_f3_ok || w_misalign || (!w_in_range && !w_is_mmio);
    assign w_mem_we = w_accept && req_we && !w_fault && !w_is_mmio;

    always_comb begin
        w_load_data = 32'd0;
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_data = w_lane;
            3'b100:  w_load_data = {24'd0, w_lane[7:0]};
            3'b101:  w_load_data = {16'd0, w_lane[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // Memory has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'd0;
            r_rsp_err    <= 1'b0;
            r_mmio_valid <= 1'b0;
            r_mmio_data  <= 8'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (req_we && w_is_mmio && !w_fault) begin
                            r_state      <= S_MMIO;
                            r_mmio_valid <= 1'b1;
                            r_mmio_data  <= req_wdata[7:0];
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_fault;
                            if (!w_fault && !req_we) begin
                                r_rsp_rdata <= w_is_mmio ? {31'd0, r_mmio_valid} : w_load_data;
                            end
                        end
                    end
                end
                S_MMIO: begin
                    if (mmio_ready) begin
                        r_state      <= S_RESP;
                        r_mmio_valid <= 1'b0;
                        r_mmio_data  <= 8'd0;
                        r_rsp_valid  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem
// Brief    : Self-checking bench for lsu_dmem: byte-level reference model,
//            per-cycle output compare, directed literals and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] MMIO  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mmio_valid;
    logic [7:0]  mmio_data;
    logic        mmio_ready = 1'b0;

    lsu_dmem #(.DEPTH(DEPTH), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mmio_valid(mmio_valid), .mmio_data(mmio_data), .mmio_ready(mmio_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mb [0:4*DEPTH-1];
    localparam int P_IDLE = 0, P_RESP = 1, P_MMIO = 2;
    int          ph = P_IDLE;
    logic [31:0] e_rd = 32'd0;
    logic        e_err = 1'b0;
    logic [7:0]  e_md = 8'd0;

    initial for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'd0;

    function automatic void predict(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, output logic go,
                                    output logic [31:0] rd, output logic er);
        int   size;
        logic legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        er    = !legal || (legal && (a % size) != 0) || (a >= 4*DEPTH && a != MMIO);
        go    = 1'b0;
        rd    = 32'd0;
        if (er) return;
        if (a == MMIO) begin
            go = we;
        end else if (we) begin
            for (int i = 0; i < size; i++) mb[a+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[a+i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        logic go;
        logic [31:0] rd;
        logic er;
        if (!reset) begin
            ph = P_IDLE; e_rd = 32'd0; e_err = 1'b0;
        end else if (ph == P_IDLE) begin
            if (req_valid) begin
                predict(req_we, req_funct3, req_addr, req_wdata, go, rd, er);
                if (go) begin ph = P_MMIO; e_md = req_wdata[7:0]; end
                else begin ph = P_RESP; e_rd = rd; e_err = er; end
            end
        end else if (ph == P_MMIO) begin
            if (mmio_ready) begin ph = P_RESP; e_rd = 32'd0; e_err = 1'b0; end
        end else begin
            ph = P_IDLE;
        end
    end

    // Every cycle: all outputs against the model's phase.
    always @(negedge clk) begin
        logic [43:0] act, exp;
        act = {req_ready, rsp_valid, rsp_err, mmio_valid, rsp_rdata,
               (ph == P_MMIO) ? mmio_data : 8'd0};
        exp = {ph == P_IDLE, ph == P_RESP, (ph == P_RESP) ? e_err : 1'b0, ph == P_MMIO,
               (ph == P_RESP) ? e_rd : 32'd0, (ph == P_MMIO) ? e_md : 8'd0};
        check("cycle", 64'(act), 64'(exp));
    end

    // ---------------- driver ----------------
    logic [7:0] last_md;

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int delay,
                       output logic [31:0] rd, output logic er, output int lat);
        int held;
        bit got;
        held = 0; got = 0; lat = 0; rd = 32'hX; er = 1'bX;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        mmio_ready = (we && a == MMIO) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = 1'b0;
                req_wdata = $urandom; req_addr = $urandom;
            end
            if (rsp_valid) begin
                got = 1; lat = i; rd = rsp_rdata; er = rsp_err;
            end else if (mmio_valid) begin
                last_md = mmio_data;
                held++;
                if (held >= delay) mmio_ready = 1'b1;
            end
        end
        mmio_ready = 1'b0;
        if (!got) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input string nm,
                      input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, f3, a, 32'd0, 0, rd, er, lat);
        check({nm, "_rdata"}, 64'(rd), 64'(exp_rd));
        check({nm, "_err"}, 64'(er), 64'(exp_er));
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input string nm, input logic exp_er);
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, f3, a, wd, 0, rd, er, lat);
        check({nm, "_err"}, 64'(er), 64'(exp_er));
    endtask

    initial begin
        logic [31:0] rd; logic er; int lat;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, mmio_valid, rsp_rdata, mmio_data}),
                 64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0}));
        @(posedge clk); #2 reset = 1'b1;

        st(3'b010, 32'h10, 32'hDEADBEEF, "sw_10", 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        check("lw_10_rdata", 64'(rd), 64'h DEADBEEF);
        check("lw_10_latency", 64'(lat), 64'd1);
        st(3'b000, 32'h13, 32'h80, "sb_13", 1'b0);
        ld(3'b010, 32'h10, "lw_after_sb", 32'h80ADBEEF, 1'b0);
        ld(3'b000, 32'h13, "lb_13", 32'hFFFFFF80, 1'b0);
        ld(3'b100, 32'h13, "lbu_13", 32'h00000080, 1'b0);
        ld(3'b101, 32'h12, "lhu_12", 32'h000080AD, 1'b0);
        ld(3'b001, 32'h12, "lh_12", 32'hFFFF80AD, 1'b0);
        ld(3'b010, 32'h11, "lw_misaligned", 32'd0, 1'b1);
        st(3'b001, 32'h11, 32'hFFFF, "sh_misaligned", 1'b1);
        ld(3'b010, 32'h10, "lw_after_bad_sh", 32'h80ADBEEF, 1'b0);
        ld(3'b010, 32'h1000, "lw_range", 32'd0, 1'b1);
        ld(3'b011, 32'h10, "f3_011", 32'd0, 1'b1);
        st(3'b100, 32'h10, 32'h0, "store_f3_100", 1'b1);

        txn(1'b1, 3'b000, MMIO, 32'h41, 3, rd, er, lat);
        check("mmio_data", 64'(last_md), 64'h41);
        check("mmio_latency", 64'(lat), 64'd4);
        check("mmio_rsp", 64'({er, rd}), 64'd0);
        ld(3'b010, MMIO, "lw_mmio", 32'd0, 1'b0);

        // Reset in the middle of an MMIO handshake.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = MMIO; req_wdata = 32'h42;
        mmio_ready = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        check("mmio_pending", 64'({mmio_valid, mmio_data}), 64'({1'b1, 8'h42}));
        #2 reset = 1'b0;
        #1 check("mmio_abort", 64'({mmio_valid, rsp_valid, req_ready}), 64'({1'b0, 1'b0, 1'b1}));
        mmio_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1; mmio_ready = 1'b0;
        ld(3'b010, 32'h10, "lw_after_reset", 32'h80ADBEEF, 1'b0);

        // Random traffic over a pre-initialised window.
        for (int w = 0; w < 16; w++) st(3'b010, 32'(4*w), $urandom, "init", 1'b0);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       a = MMIO;
                1:       a = 32'h1000 + $urandom_range(0, 255);
                default: a = 32'($urandom_range(0, 63));
            endcase
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                $urandom_range(0, 3), rd, er, lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
